// File: rtl/hub75_line_capture_if.sv
// hub75_line_capture_if: HUB75 pin bundle plus the reconstructed pixel-beat stream.
`default_nettype none

interface hub75_line_capture_if #(
  parameter int ADDR_BITS   = 5,
  parameter int ONTIME_BITS = 16,
  parameter int X_BITS      = 6
);
  logic                   hub75_oe;
  logic                   hub75_clk;
  logic                   hub75_lat;
  logic [ADDR_BITS-1:0]   hub75_addr;
  logic [5:0]             hub75_rgb;

  logic                   out_valid;
  logic                   out_ready;
  logic [X_BITS-1:0]      out_x;
  logic [ADDR_BITS-1:0]   out_row;
  logic [2:0]             out_plane;
  logic [5:0]             out_rgb;
  logic                   out_last;
  logic [ONTIME_BITS-1:0] out_ontime;
  logic                   err_overflow;
  logic                   err_short;

  modport slave (
    input  hub75_oe, hub75_clk, hub75_lat, hub75_addr, hub75_rgb, out_ready,
    output out_valid, out_x, out_row, out_plane, out_rgb, out_last, out_ontime,
           err_overflow, err_short
  );

  modport master (
    output hub75_oe, hub75_clk, hub75_lat, hub75_addr, hub75_rgb, out_ready,
    input  out_valid, out_x, out_row, out_plane, out_rgb, out_last, out_ontime,
           err_overflow, err_short
  );
endinterface

`default_nettype wire

// File: rtl/hub75_line_capture.sv
// hub75_line_capture: panel-side HUB75 receiver turning latched lines into tagged pixel beats.
`default_nettype none

module hub75_line_capture #(
  parameter int WIDTH       = 64,
  parameter int ADDR_BITS   = 5,
  parameter int BIT_DEPTH   = 8,
  parameter int SYNC_STAGES = 2,
  parameter int ONTIME_BITS = 16
) (
  input  wire logic             CLK,
  input  wire logic             RST,
  hub75_line_capture_if.slave   bus
);
  localparam int XW     = $clog2(WIDTH);
  localparam int CW     = $clog2(WIDTH + 2);
  localparam int PW     = 3;
  localparam int SYNC_W = 9 + ADDR_BITS;
  localparam int LB_W   = WIDTH * 6;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_STREAM = 1'b1;

  logic [SYNC_W-1:0]      r_sync [SYNC_STAGES];
  logic                   r_prev_clk;
  logic                   r_prev_lat;
  logic [LB_W-1:0]        r_sreg;
  logic [CW-1:0]          r_shift_cnt;
  logic [ADDR_BITS-1:0]   r_row_tag;
  logic                   r_first;
  logic [ADDR_BITS-1:0]   r_prev_row;
  logic                   r_seen;
  logic [PW-1:0]          r_plane;
  logic [ONTIME_BITS-1:0] r_ontime_cnt;
  logic [LB_W-1:0]        r_linebuf;
  logic [ADDR_BITS-1:0]   r_line_row;
  logic [PW-1:0]          r_line_plane;
  logic [ONTIME_BITS-1:0] r_line_ontime;
  logic                   r_err_overflow;
  logic                   r_err_short;
  logic [0:0]             r_state;
  logic [XW-1:0]          r_x;

  logic [SYNC_W-1:0]      w_pins;
  logic [SYNC_W-1:0]      w_s;
  logic [5:0]             w_s_rgb;
  logic [ADDR_BITS-1:0]   w_s_addr;
  logic                   w_s_lat;
  logic                   w_s_clk;
  logic                   w_s_oe;
  logic                   w_clk_rise;
  logic                   w_lat_rise;
  logic [LB_W-1:0]        w_sreg_nxt;
  logic [CW-1:0]          w_cnt_nxt;
  logic [ADDR_BITS-1:0]   w_row_nxt;
  logic [PW-1:0]          w_plane_nxt;
  logic [0:0]             w_state_nxt;
  logic [XW-1:0]          w_x_nxt;

  assign w_pins     = {bus.hub75_oe, bus.hub75_clk, bus.hub75_lat, bus.hub75_addr, bus.hub75_rgb};
  assign w_s        = r_sync[SYNC_STAGES-1];
  assign w_s_rgb    = w_s[5:0];
  assign w_s_addr   = w_s[6 +: ADDR_BITS];
  assign w_s_lat    = w_s[6 + ADDR_BITS];
  assign w_s_clk    = w_s[7 + ADDR_BITS];
  assign w_s_oe     = w_s[8 + ADDR_BITS];
  assign w_clk_rise = w_s_clk & ~r_prev_clk;
  assign w_lat_rise = w_s_lat & ~r_prev_lat;

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= w_pins;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  // The shift is resolved first so a latch in the same cycle sees the post-shift line.
  always_comb begin
    w_sreg_nxt = r_sreg;
    w_cnt_nxt  = r_shift_cnt;
    w_row_nxt  = r_row_tag;
    if (w_clk_rise) begin
      w_sreg_nxt = {w_s_rgb, r_sreg[LB_W-1:6]};
      if (r_shift_cnt != CW'(WIDTH + 1)) w_cnt_nxt = r_shift_cnt + 1'b1;
      if (r_first) w_row_nxt = w_s_addr;
    end
  end

  always_comb begin
    w_plane_nxt = '0;
    if (r_seen && (w_row_nxt == r_prev_row))
      w_plane_nxt = (r_plane == PW'(BIT_DEPTH - 1)) ? '0 : r_plane + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_prev_clk     <= 1'b0;
      r_prev_lat     <= 1'b0;
      r_sreg         <= '0;
      r_shift_cnt    <= '0;
      r_row_tag      <= '0;
      r_first        <= 1'b1;
      r_prev_row     <= '0;
      r_seen         <= 1'b0;
      r_plane        <= '0;
      r_ontime_cnt   <= '0;
      r_linebuf      <= '0;
      r_line_row     <= '0;
      r_line_plane   <= '0;
      r_line_ontime  <= '0;
      r_err_overflow <= 1'b0;
      r_err_short    <= 1'b0;
    end else begin
      r_prev_clk  <= w_s_clk;
      r_prev_lat  <= w_s_lat;
      r_sreg      <= w_sreg_nxt;
      r_shift_cnt <= w_cnt_nxt;
      r_row_tag   <= w_row_nxt;
      if (w_clk_rise) r_first <= 1'b0;
      if (!w_s_oe && (r_ontime_cnt != '1)) r_ontime_cnt <= r_ontime_cnt + 1'b1;
      if (w_lat_rise) begin
        // A latch while the previous line is still draining drops the new line only.
        if (r_state == S_STREAM) begin
          r_err_overflow <= 1'b1;
        end else begin
          r_linebuf     <= w_sreg_nxt;
          r_line_row    <= w_row_nxt;
          r_line_plane  <= w_plane_nxt;
          r_line_ontime <= r_ontime_cnt;
        end
        if (w_cnt_nxt != CW'(WIDTH)) r_err_short <= 1'b1;
        r_shift_cnt  <= '0;
        r_ontime_cnt <= '0;
        r_first      <= 1'b1;
        r_plane      <= w_plane_nxt;
        r_prev_row   <= w_row_nxt;
        r_seen       <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_x     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_x     <= w_x_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    case (r_state)
      S_IDLE: begin
        if (w_lat_rise) begin
          w_state_nxt = S_STREAM;
          w_x_nxt     = '0;
        end
      end
      S_STREAM: begin
        if (bus.out_ready) begin
          if (r_x == XW'(WIDTH - 1)) begin
            w_state_nxt = S_IDLE;
            w_x_nxt     = '0;
          end else begin
            w_x_nxt = r_x + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_x_nxt     = '0;
      end
    endcase
  end

  always_comb begin
    bus.out_valid  = 1'b0;
    bus.out_x      = '0;
    bus.out_row    = '0;
    bus.out_plane  = '0;
    bus.out_rgb    = '0;
    bus.out_last   = 1'b0;
    bus.out_ontime = '0;
    if (r_state == S_STREAM) begin
      bus.out_valid  = 1'b1;
      bus.out_x      = r_x;
      bus.out_row    = r_line_row;
      bus.out_plane  = r_line_plane;
      bus.out_rgb    = r_linebuf[r_x*6 +: 6];
      bus.out_last   = (r_x == XW'(WIDTH - 1));
      bus.out_ontime = r_line_ontime;
    end
  end

  assign bus.err_overflow = r_err_overflow;
  assign bus.err_short    = r_err_short;
endmodule

`default_nettype wire

// File: tb/tb_hub75_line_capture.sv
// tb_hub75_line_capture: directed HUB75 line stimulus with a queued expected-beat scoreboard.
`default_nettype none

module tb_hub75_line_capture;
  logic CLK = 1'b0;
  logic RST = 1'b1;

  always #5 CLK = ~CLK;

  hub75_line_capture_if #(.ADDR_BITS(5), .ONTIME_BITS(16), .X_BITS(6)) bus ();

  hub75_line_capture #(
    .WIDTH(64), .ADDR_BITS(5), .BIT_DEPTH(8), .SYNC_STAGES(2), .ONTIME_BITS(16)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  typedef struct {
    int x;
    int row;
    int plane;
    int rgb;
    int last;
    int ontime;
    bit chk_ot;
  } beat_t;

  beat_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] pat(int seed, int x);
    if (seed == 0) return 6'h15;
    return 6'((x * seed + 3) % 64);
  endfunction

  // Scoreboard monitor: compares every accepted beat against the queue head.
  always @(negedge CLK) begin
    beat_t e;
    if (RST) begin
      q.delete();
    end else if (bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        check("unexpected_beat", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("x", bus.out_x, e.x);
        check("row", bus.out_row, e.row);
        check("plane", bus.out_plane, e.plane);
        check("rgb", bus.out_rgb, e.rgb);
        check("last", bus.out_last, e.last);
        if (e.chk_ot) check("ontime", bus.out_ontime, e.ontime);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic col(logic [4:0] a, logic [5:0] rgb, bit lat);
    bus.hub75_clk  = 1'b0;
    bus.hub75_lat  = 1'b0;
    bus.hub75_addr = a;
    bus.hub75_rgb  = rgb;
    tick(2);
    bus.hub75_clk = 1'b1;
    bus.hub75_lat = lat;
    tick(2);
    bus.hub75_clk = 1'b0;
    bus.hub75_lat = 1'b0;
  endtask

  task automatic latch_only();
    bus.hub75_lat = 1'b1;
    tick(2);
    bus.hub75_lat = 1'b0;
    tick(2);
  endtask

  task automatic push_line(int row, int seed, int off, int plane, int ot, bit chk);
    beat_t b;
    for (int x = 0; x < 64; x++) begin
      b.x      = x;
      b.row    = row;
      b.plane  = plane;
      b.rgb    = (x < off) ? 0 : int'(pat(seed, x - off));
      b.last   = (x == 63) ? 1 : 0;
      b.ontime = ot;
      b.chk_ot = chk;
      q.push_back(b);
    end
  endtask

  // Full 64-column line, clock and latch rising together on the last column.
  task automatic send_line(logic [4:0] a, int seed, int plane, int ot, bit chk, bit push, int gap);
    for (int j = 0; j < 64; j++) begin
      if (j == 10 && gap > 0) begin
        bus.hub75_oe = 1'b0;
        tick(gap);
        bus.hub75_oe = 1'b1;
      end
      if (j == 63 && push) push_line(int'(a), seed, 0, plane, ot, chk);
      col(a, pat(seed, j), j == 63);
    end
  endtask

  task automatic drain(string name);
    int n = 0;
    while ((q.size() != 0 || bus.out_valid) && n < 1000) begin
      @(negedge CLK);
      n++;
    end
    check({"drain_", name}, (n < 1000) ? 32'd1 : 32'd0, 32'd1);
    tick(1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int n;
    bus.hub75_oe   = 1'b1;
    bus.hub75_clk  = 1'b0;
    bus.hub75_lat  = 1'b0;
    bus.hub75_addr = '0;
    bus.hub75_rgb  = '0;
    bus.out_ready  = 1'b1;
    RST = 1'b1;
    tick(3);
    RST = 1'b0;
    check("rst_valid", bus.out_valid, 0);
    check("rst_last", bus.out_last, 0);
    check("rst_x", bus.out_x, 0);
    check("rst_ovf", bus.err_overflow, 0);
    check("rst_short", bus.err_short, 0);

    // Single line, constant colour.
    send_line(5'd3, 0, 0, 0, 1'b0, 1'b1, 0);
    drain("single");
    check("single_ovf", bus.err_overflow, 0);
    check("single_short", bus.err_short, 0);

    // Eight planes on row 5, then row 6, then back to row 5.
    for (int i = 0; i < 8; i++) begin
      send_line(5'd5, 5 + 2 * i, i, 0, 1'b1, 1'b1, 0);
      drain("plane");
    end
    send_line(5'd6, 9, 0, 0, 1'b1, 1'b1, 0);
    drain("row6");
    send_line(5'd5, 13, 0, 0, 1'b1, 1'b1, 0);
    drain("row5_again");

    // Backpressure: line A held while line B overflows.
    bus.out_ready = 1'b0;
    send_line(5'd7, 17, 0, 0, 1'b1, 1'b1, 0);
    tick(4);
    for (int j = 0; j < 64; j++) begin
      if (j % 16 == 0) begin
        check("stall_valid", bus.out_valid, 1);
        check("stall_x", bus.out_x, 0);
        check("stall_rgb", bus.out_rgb, pat(17, 0));
      end
      col(5'd7, pat(19, j), j == 63);
    end
    tick(4);
    check("ovf_set", bus.err_overflow, 1);
    check("ovf_short", bus.err_short, 0);
    check("ovf_hold_x", bus.out_x, 0);
    bus.out_ready = 1'b1;
    drain("overflow");

    // Short line after a fresh reset, then a good line.
    RST = 1'b1;
    tick(2);
    RST = 1'b0;
    check("rst2_ovf", bus.err_overflow, 0);
    for (int j = 0; j < 40; j++) col(5'd4, pat(21, j), 1'b0);
    push_line(4, 21, 24, 0, 0, 1'b0);
    latch_only();
    drain("short");
    check("short_set", bus.err_short, 1);
    send_line(5'd4, 23, 1, 0, 1'b1, 1'b1, 0);
    drain("after_short");
    check("short_sticky", bus.err_short, 1);

    // OE low for 37 cycles between latches.
    send_line(5'd4, 29, 2, 37, 1'b1, 1'b1, 37);
    drain("ontime");

    // Reset mid-stream at beat 20.
    send_line(5'd9, 25, 0, 0, 1'b1, 1'b1, 0);
    n = 0;
    while (!(bus.out_valid && bus.out_x == 6'd20) && n < 300) begin
      @(negedge CLK);
      n++;
    end
    check("reach_x20", (n < 300) ? 32'd1 : 32'd0, 32'd1);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check("midrst_valid", bus.out_valid, 0);
    check("midrst_last", bus.out_last, 0);
    check("midrst_short", bus.err_short, 0);
    check("midrst_ovf", bus.err_overflow, 0);
    tick(1);
    RST = 1'b0;
    send_line(5'd9, 27, 0, 0, 1'b0, 1'b1, 0);
    drain("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
